// File: rtl/data_mem_responder_pkg.sv
// Shared data-bus constants: timer page base, register indices, CTRL bit positions.
// Also used by the CPU side so both agree on the MMIO map.
package data_mem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CTRL    = 2'd3
  } timer_reg_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTOCLR = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_W       = 3;

  typedef struct packed {
    logic       we;
    timer_reg_e idx;
    logic [3:0] sel;
    logic [31:0] wdata;
  } timer_req_t;

  // Byte-lane merge: sel[n] selects bits [8n+7:8n] (sel[3] is the MSB lane).
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int n = 0; n < 4; n++)
      if (sel[n]) res[8*n +: 8] = new_w[8*n +: 8];
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// Timer register page: free-running COUNT with COMPARE match, sticky STATUS flag
// (write-1-clear) and CTRL enables. Reads are combinational from the registers.
module mmio_timer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  timer_req_t  i_req,
  input  logic [1:0]  i_rd_idx,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  logic [31:0]       r_count, r_compare;
  logic              r_status;
  logic [CTRL_W-1:0] r_ctrl;

  logic [31:0]       w_count_nxt, w_compare_nxt;
  logic              w_status_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic              w_match;
  logic              w_wr_count, w_wr_compare, w_wr_status, w_wr_ctrl;

  always_comb begin
    w_wr_count    = i_req.we && (i_req.idx == REG_COUNT);
    w_wr_compare  = i_req.we && (i_req.idx == REG_COMPARE);
    w_wr_status   = i_req.we && (i_req.idx == REG_STATUS);
    w_wr_ctrl     = i_req.we && (i_req.idx == REG_CTRL);
    // Match always looks at the registered COUNT, before any same-cycle write.
    w_match       = r_ctrl[CTRL_EN] && (r_count == r_compare);

    w_count_nxt   = r_count;
    w_compare_nxt = r_compare;
    w_status_nxt  = r_status;
    w_ctrl_nxt    = r_ctrl;

    if (w_wr_count)
      w_count_nxt = lane_merge(r_count, i_req.wdata, i_req.sel);
    else if (w_match && r_ctrl[CTRL_AUTOCLR])
      w_count_nxt = '0;
    else if (r_ctrl[CTRL_EN])
      w_count_nxt = r_count + 32'd1;

    if (w_wr_compare)
      w_compare_nxt = lane_merge(r_compare, i_req.wdata, i_req.sel);

    if (w_wr_ctrl && i_req.sel[0])
      w_ctrl_nxt = i_req.wdata[CTRL_W-1:0];

    // A same-cycle match beats the write-1-clear.
    if (w_match)
      w_status_nxt = 1'b1;
    else if (w_wr_status && i_req.sel[0] && i_req.wdata[0])
      w_status_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_status  <= 1'b0;
      r_ctrl    <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_compare <= w_compare_nxt;
      r_status  <= w_status_nxt;
      r_ctrl    <= w_ctrl_nxt;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_rd_idx)
      REG_COUNT:   o_rdata = r_count;
      REG_COMPARE: o_rdata = r_compare;
      REG_STATUS:  o_rdata = {31'b0, r_status};
      REG_CTRL:    o_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
      default:     o_rdata = '0;
    endcase
  end

  assign o_irq = ~rst & r_status & r_ctrl[CTRL_IE];

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-bus slave: zero-latency word RAM with byte-lane writes, plus the
// timer register page at MMIO_BASE. Everything else reads 0 and ignores writes.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        timer_irq_o
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       r_mem [RAM_WORDS];

  logic              w_ram_hit, w_mmio_hit;
  logic              w_ram_wr;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0]       w_timer_rdata;
  timer_req_t        w_treq;
  logic              w_unused;

  assign w_ram_hit  = (addr_i[31:RAM_AW+2] == '0);
  assign w_mmio_hit = (addr_i[31:4] == MMIO_BASE[31:4]);
  assign w_idx      = addr_i[RAM_AW+1:2];
  assign w_ram_wr   = ce_i && we_i && w_ram_hit && !rst;
  // Byte offset bits never select a word; lanes come from sel_i only.
  assign w_unused   = &{1'b0, addr_i[1:0]};

  // RAM has no reset; writes are simply blocked while rst is high.
  always_ff @(posedge clk) begin
    if (w_ram_wr)
      for (int n = 0; n < 4; n++)
        if (sel_i[n]) r_mem[w_idx][8*n +: 8] <= data_i[8*n +: 8];
  end

  always_comb begin
    w_treq       = '0;
    w_treq.we    = ce_i && we_i && w_mmio_hit;
    w_treq.idx   = timer_reg_e'(addr_i[3:2]);
    w_treq.sel   = sel_i;
    w_treq.wdata = data_i;
  end

  mmio_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_treq),
    .i_rd_idx (addr_i[3:2]),
    .o_rdata  (w_timer_rdata),
    .o_irq    (timer_irq_o)
  );

  // Reads see the array before any same-edge write, so read-during-write is old data.
  always_comb begin
    data_o = '0;
    if (!rst && ce_i && !we_i) begin
      if (w_ram_hit)
        data_o = r_mem[w_idx];
      else if (w_mmio_hit)
        data_o = w_timer_rdata;
    end
  end

endmodule
